// File: rtl/muldiv_exec.sv
// muldiv_exec: multi-cycle unsigned multiply/divide execute unit.
// Captures operands from the register file read ports, iterates one bit per
// cycle for DATA_WIDTH cycles, then issues a single-cycle register write-back.
// Latency is DATA_WIDTH+1 cycles for every op, divide by zero included.
module muldiv_exec #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] opa_i,
    input  logic [DATA_WIDTH-1:0] opb_i,
    input  logic [ADDR_WIDTH-1:0] dest_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic                  wb_we_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] OP_MULL = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WB   = 2'b10
    } state_t;

    state_t          state;
    logic [1:0]      op;
    logic [ADDR_WIDTH-1:0] dest;
    logic [CW-1:0]   count;

    // Multiply datapath: upper half accumulates, lower half starts as the
    // multiplier and is shifted out one bit per cycle.
    logic [2*W-1:0]  prod;
    logic [W-1:0]    mcand;

    // Divide datapath: W+1-bit partial remainder, dividend shifts out of quo
    // from the top while quotient bits shift in at the bottom.
    logic [W:0]      rem;
    logic [W-1:0]    quo;
    logic [W-1:0]    divisor;

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  prod_next;
    logic [W:0]      rem_shift;
    logic            div_ge;
    logic [W:0]      rem_next;
    logic [W-1:0]    quo_next;
    logic [W-1:0]    result;
    logic            last_iter;

    // One iteration of both datapaths, plus the result as it will stand after
    // the current iteration (used to register wb_data_o on the final step).
    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        prod_next = {mul_sum, prod[W-1:1]};

        // With a zero divisor the compare always succeeds and nothing is
        // subtracted, so the quotient saturates to all ones and the remainder
        // ends up equal to the dividend -- exactly the required div-by-zero
        // results, with no special casing.
        rem_shift = {rem[W-1:0], quo[W-1]};
        div_ge    = (rem_shift >= {1'b0, divisor});
        rem_next  = div_ge ? (rem_shift - {1'b0, divisor}) : rem_shift;
        quo_next  = {quo[W-2:0], div_ge};

        result = '0;
        case (op)
            OP_MULL: result = prod_next[W-1:0];
            OP_MULH: result = prod_next[2*W-1:W];
            OP_DIVU: result = quo_next;
            OP_REMU: result = rem_next[W-1:0];
            default: result = '0;
        endcase

        last_iter = (count == CW'(1));
    end

    // Control FSM with registered outputs; write-back data is latched on the
    // last RUN cycle and held until the next write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_MULL;
            dest      <= '0;
            count     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_data_o <= '0;
            wb_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state  <= RUN;
                        op     <= op_i;
                        dest   <= dest_i;
                        count  <= CW'(W);
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (last_iter) begin
                        state     <= WB;
                        done_o    <= 1'b1;
                        wb_we_o   <= 1'b1;
                        wb_data_o <= result;
                        wb_addr_o <= dest;
                    end
                end
                WB: begin
                    state   <= IDLE;
                    done_o  <= 1'b0;
                    wb_we_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    done_o  <= 1'b0;
                    wb_we_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Arithmetic registers: load on issue, step only the datapath the op uses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod    <= '0;
            mcand   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
        end else if (state == IDLE && start_i) begin
            prod    <= {{W{1'b0}}, opa_i};
            mcand   <= opb_i;
            rem     <= '0;
            quo     <= opa_i;
            divisor <= opb_i;
        end else if (state == RUN) begin
            if (op[1]) begin
                rem <= rem_next;
                quo <= quo_next;
            end else begin
                prod <= prod_next;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_exec.sv
// Directed self-checking bench for muldiv_exec (DATA_WIDTH=32, ADDR_WIDTH=3).
module tb_muldiv_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic [2:0]  dest_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] wb_data_o;
    logic [2:0]  wb_addr_o;
    logic        wb_we_o;

    int checks = 0;
    int errors = 0;

    muldiv_exec #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .opa_i     (opa_i),
        .opb_i     (opb_i),
        .dest_i    (dest_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .wb_data_o (wb_data_o),
        .wb_addr_o (wb_addr_o),
        .wb_we_o   (wb_we_o)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; op_i = 2'b00;
        opa_i = '0; opb_i = '0; dest_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done_o); end
        checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL reset we got %b want 0", wb_we_o); end
        checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL reset data got %h want 0", wb_data_o); end
        checks++; if (wb_addr_o !== 3'h0) begin errors++; $display("FAIL reset addr got %h want 0", wb_addr_o); end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL idle we cyc %0d got %b want 0", i, wb_we_o); end
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle busy cyc %0d got %b want 0", i, busy_o); end
        end
    endtask

    // Issue one op, scramble the inputs right after issue, and check every
    // cycle up to the following IDLE cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] dest, input logic [31:0] exp, input string name);
        @(negedge clk);
        start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; dest_i = dest;
        @(posedge clk);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_i = 1'b0; op_i = ~op; opa_i = ~a; opb_i = a ^ b; dest_i = ~dest;
            end
            checks++; if (busy_o !== (k <= 33)) begin errors++; $display("FAIL %s busy k=%0d got %b want %b", name, k, busy_o, (k <= 33)); end
            checks++; if (wb_we_o !== (k == 33)) begin errors++; $display("FAIL %s we k=%0d got %b want %b", name, k, wb_we_o, (k == 33)); end
            checks++; if (done_o !== (k == 33)) begin errors++; $display("FAIL %s done k=%0d got %b want %b", name, k, done_o, (k == 33)); end
            if (k >= 33) begin
                checks++; if (wb_data_o !== exp) begin errors++; $display("FAIL %s data k=%0d got %h want %h", name, k, wb_data_o, exp); end
                checks++; if (wb_addr_o !== dest) begin errors++; $display("FAIL %s addr k=%0d got %0d want %0d", name, k, wb_addr_o, dest); end
            end
        end
    endtask

    task automatic test_mul();
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 3'd5, 32'hFFFF_FFFE, "mull");
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 3'd5, 32'h0000_0001, "mulh");
        // 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0001, "mull_max");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'hFFFF_FFFE, "mulh_max");
    endtask

    task automatic test_div();
        run_op(2'b10, 32'd100, 32'd7, 3'd3, 32'd14, "divu");
        run_op(2'b11, 32'd100, 32'd7, 3'd3, 32'd2,  "remu");
        run_op(2'b10, 32'd5,   32'd9, 3'd6, 32'd0,  "divu_small");
        run_op(2'b11, 32'd5,   32'd9, 3'd6, 32'd5,  "remu_small");
    endtask

    task automatic test_div_zero();
        run_op(2'b10, 32'h1234_5678, 32'h0, 3'd4, 32'hFFFF_FFFF, "divu_zero");
        run_op(2'b11, 32'h1234_5678, 32'h0, 3'd4, 32'h1234_5678, "remu_zero");
    endtask

    // start_i held high with operands changing every cycle; only the table
    // entries driven on the IDLE edges (every 34 cycles) may be accepted.
    task automatic test_back_to_back();
        logic [1:0]  t_op   [3];
        logic [31:0] t_a    [3];
        logic [31:0] t_b    [3];
        logic [2:0]  t_dest [3];
        logic [31:0] t_exp  [3];
        int          idx;
        int          m;
        t_op[0] = 2'b01; t_a[0] = 32'h8000_0000; t_b[0] = 32'd6;    t_dest[0] = 3'd6; t_exp[0] = 32'd3;
        t_op[1] = 2'b10; t_a[1] = 32'd1000;      t_b[1] = 32'd10;   t_dest[1] = 3'd1; t_exp[1] = 32'd100;
        t_op[2] = 2'b11; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'h10;   t_dest[2] = 3'd7; t_exp[2] = 32'hF;
        idx = 0;
        @(negedge clk);
        for (int c = 0; c < 102; c++) begin
            start_i = 1'b1;
            if (c % 34 == 0) begin
                idx = c / 34;
                op_i = t_op[idx]; opa_i = t_a[idx]; opb_i = t_b[idx]; dest_i = t_dest[idx];
            end else begin
                op_i = 2'(c); opa_i = 32'(c * 3 + 1); opb_i = 32'(c + 2); dest_i = 3'(c);
            end
            @(posedge clk);
            @(negedge clk);
            m = (c + 1) % 34;
            checks++; if (busy_o !== (m != 0)) begin errors++; $display("FAIL b2b busy cyc %0d got %b want %b", c + 1, busy_o, (m != 0)); end
            checks++; if (wb_we_o !== (m == 33)) begin errors++; $display("FAIL b2b we cyc %0d got %b want %b", c + 1, wb_we_o, (m == 33)); end
            if (m == 33) begin
                checks++; if (wb_data_o !== t_exp[idx]) begin errors++; $display("FAIL b2b data op%0d got %h want %h", idx, wb_data_o, t_exp[idx]); end
                checks++; if (wb_addr_o !== t_dest[idx]) begin errors++; $display("FAIL b2b addr op%0d got %0d want %0d", idx, wb_addr_o, t_dest[idx]); end
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b tail busy got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; opa_i = 32'd3; opb_i = 32'd5; dest_i = 3'd2;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b want 0", busy_o); end
        checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_mid we got %b want 0", wb_we_o); end
        checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL rst_mid data got %h want 0", wb_data_o); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_mid stray we cyc %0d got %b want 0", i, wb_we_o); end
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid stray busy cyc %0d got %b want 0", i, busy_o); end
        end
        run_op(2'b00, 32'd3, 32'd5, 3'd2, 32'd15, "post_rst");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
